// File: rtl/id_ex_issue.sv
// ---------------------------------------------------------------------------
// id_ex_issue
//
// ID/EX pipeline register that feeds the EX-stage ALU. The instruction in ID
// is decoded into the ALU operation code and operand select, and is then
// registered along with its two register-file operands. A load in EX whose
// destination is read by the instruction in ID holds ID for one cycle. A
// bubble is sent into EX during that cycle. EX back-pressure freezes the
// register. A flush replaces the EX entry with a bubble.
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   reset        : asynchronous, active-high reset
//   id_valid     : ID holds a valid instruction
//   id_instru    : ID instruction word
//   id_read1     : register-file rs value
//   id_read2     : register-file rt value
//   ex_ready     : EX accepts a new entry (0 = hold the EX register)
//   flush        : kill the EX entry (branch taken / mispredict)
//   id_ready     : ID instruction consumed this cycle (combinational)
//   hazard_stall : load-use hazard detected this cycle (combinational)
//   ex_valid     : EX register holds a real instruction
//   data1        : ALU operand 1 (registered rs value)
//   read2        : ALU read2 (registered rt value)
//   instru       : registered instruction word (ALU sign-extends [15:0])
//   ALUSrc       : 1 = ALU uses the sign-extended immediate
//   ALUcontrol   : ALU operation (0000 AND, 0001 OR, 0010 ADD, 0110 SUB,
//                  0111 SLT, 1100 NOR)
//   ex_memread   : EX instruction is lw
//   ex_rt        : rt field of the EX instruction
//   illegal      : EX instruction opcode/funct is not decodable
//   stall_count  : load-use bubbles inserted, saturates at all-ones
// ---------------------------------------------------------------------------
module id_ex_issue #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [31:0]            id_instru,
  input  logic [31:0]            id_read1,
  input  logic [31:0]            id_read2,
  input  logic                   ex_ready,
  input  logic                   flush,
  output logic                   id_ready,
  output logic                   hazard_stall,
  output logic                   ex_valid,
  output logic [31:0]            data1,
  output logic [31:0]            read2,
  output logic [31:0]            instru,
  output logic                   ALUSrc,
  output logic [3:0]             ALUcontrol,
  output logic                   ex_memread,
  output logic [4:0]             ex_rt,
  output logic                   illegal,
  output logic [STALL_CNT_W-1:0] stall_count
);

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operation codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef struct packed {
    logic [3:0] alu_ctl;
    logic       alu_src;
    logic       mem_read;
    logic       rt_src;
    logic       bad;
  } dec_t;

  // Undecodable encodings fall back to ADD/register operand and are flagged.
  // Such an instruction still issues, so that EX can raise the exception.
  function automatic dec_t decode(input logic [31:0] ins);
    dec_t d;
    d.alu_ctl  = ALU_ADD;
    d.alu_src  = 1'b0;
    d.mem_read = 1'b0;
    d.rt_src   = 1'b0;
    d.bad      = 1'b0;
    unique case (ins[31:26])
      OP_RTYPE: begin
        d.rt_src = 1'b1;
        unique case (ins[5:0])
          FN_ADD:  d.alu_ctl = ALU_ADD;
          FN_SUB:  d.alu_ctl = ALU_SUB;
          FN_AND:  d.alu_ctl = ALU_AND;
          FN_OR:   d.alu_ctl = ALU_OR;
          FN_NOR:  d.alu_ctl = ALU_NOR;
          FN_SLT:  d.alu_ctl = ALU_SLT;
          default: d.bad     = 1'b1;
        endcase
      end
      OP_LW: begin
        d.alu_src  = 1'b1;
        d.mem_read = 1'b1;
      end
      OP_SW: begin
        d.alu_src = 1'b1;
        d.rt_src  = 1'b1;
      end
      OP_ADDI: d.alu_src = 1'b1;
      OP_ANDI: begin
        d.alu_ctl = ALU_AND;
        d.alu_src = 1'b1;
      end
      OP_ORI: begin
        d.alu_ctl = ALU_OR;
        d.alu_src = 1'b1;
      end
      OP_SLTI: begin
        d.alu_ctl = ALU_SLT;
        d.alu_src = 1'b1;
      end
      OP_BEQ: begin
        d.alu_ctl = ALU_SUB;
        d.rt_src  = 1'b1;
      end
      default: d.bad = 1'b1;
    endcase
    return d;
  endfunction

  dec_t       dec;
  logic [4:0] id_rs;
  logic [4:0] id_rt;

  assign id_rs = id_instru[25:21];
  assign id_rt = id_instru[20:16];
  // A bubble is all zeros, so the rt field of the stored word is always the
  // right comparison source.
  assign ex_rt = instru[20:16];

  // ID decode and load-use detection
  always_comb begin
    dec          = decode(id_instru);
    // A load to $zero writes nothing, so it never creates a dependency.
    hazard_stall = id_valid & ex_valid & ex_memread & (ex_rt != 5'd0) &
                   ((ex_rt == id_rs) | (dec.rt_src & (ex_rt == id_rt)));
    id_ready     = ex_ready & ~hazard_stall & ~flush;
  end

  // ID -> EX register boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      data1       <= '0;
      read2       <= '0;
      instru      <= '0;
      ALUSrc      <= 1'b0;
      ALUcontrol  <= 4'b0000;
      ex_memread  <= 1'b0;
      illegal     <= 1'b0;
      stall_count <= '0;
    end else if (flush || (ex_ready && (hazard_stall || !id_valid))) begin
      // Bubble: flush overrides back-pressure. A load-use bubble is counted
      // only when no flush is present.
      ex_valid    <= 1'b0;
      data1       <= '0;
      read2       <= '0;
      instru      <= '0;
      ALUSrc      <= 1'b0;
      ALUcontrol  <= 4'b0000;
      ex_memread  <= 1'b0;
      illegal     <= 1'b0;
      if (!flush && hazard_stall && !(&stall_count))
        stall_count <= stall_count + 1'b1;
    end else if (ex_ready) begin
      ex_valid    <= 1'b1;
      data1       <= id_read1;
      read2       <= id_read2;
      instru      <= id_instru;
      ALUSrc      <= dec.alu_src;
      ALUcontrol  <= dec.alu_ctl;
      ex_memread  <= dec.mem_read;
      illegal     <= dec.bad;
    end
  end

endmodule
